// File: rtl/bcd_add_seq_pkg.sv
// Shared constants for the sequential packed-BCD adder: ALU opcodes, flag
// bit positions, FSM encoding and a byte-select helper.
package bcd_add_seq_pkg;

    localparam logic [2:0] ALU_OP_ADD_C = 3'b000;
    localparam logic [2:0] ALU_OP_DAA_C = 3'b011;

    localparam int FLAG_CF_BIT = 0;
    localparam int FLAG_AF_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DAA  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] r;
        case (i)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            default: r = w[31:24];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bcd_add_seq_nibble_check.sv
// Flags a packed-BCD byte in which either nibble is above 9.
module bcd_nibble_check (
    input  logic [7:0] din,
    output logic       bad
);

    assign bad = (din[7:4] > 4'd9) || (din[3:0] > 4'd9);

endmodule

// File: rtl/bcd_add_seq.sv
// Sequential packed-BCD adder that drives an external ALU: per byte, one
// binary ADD cycle followed by one decimal-adjust (DAA) cycle.
module bcd_add_seq
    import bcd_add_seq_pkg::*;
#(
    parameter logic [2:0] ALU_OP_ADD = ALU_OP_ADD_C,
    parameter logic [2:0] ALU_OP_DAA = ALU_OP_DAA_C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a_bcd,
    input  logic [31:0] b_bcd,
    input  logic        cin,
    input  logic [1:0]  len,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_cf,
    output logic        alu_af,
    input  logic [31:0] alu_out,
    input  logic [31:0] alu_flags,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic        cout,
    output logic        bcd_err
);

    state_t      state, state_next;
    logic [31:0] a_q, b_q, sum_q;
    logic [1:0]  len_q, idx;
    logic [7:0]  raw_q;
    logic        cf_q, af_q, carry_q, cout_q, err_q;

    logic [3:0]  a_bad, b_bad, active;
    logic        err_in;
    logic [7:0]  a_byte, b_byte, raw_next;
    logic        unused_ok;

    assign unused_ok = ^{alu_out[31:9], alu_flags[31:1]};

    genvar j;
    generate
        for (j = 0; j < 4; j++) begin : g_chk
            bcd_nibble_check u_chk_a (.din(a_bcd[8*j +: 8]), .bad(a_bad[j]));
            bcd_nibble_check u_chk_b (.din(b_bcd[8*j +: 8]), .bad(b_bad[j]));
            assign active[j] = (2'(j) <= len);
        end
    endgenerate

    assign err_in   = |((a_bad | b_bad) & active);
    assign a_byte   = byte_sel(a_q, idx);
    assign b_byte   = byte_sel(b_q, idx);
    assign raw_next = alu_out[7:0];

    always_comb begin
        state_next = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = ALU_OP_ADD;
        alu_cf     = 1'b0;
        alu_af     = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_ADD;
            ST_ADD: begin
                alu_a      = {24'b0, a_byte};
                alu_b      = {24'b0, b_byte} + {31'b0, carry_q};
                state_next = ST_DAA;
            end
            ST_DAA: begin
                alu_op     = ALU_OP_DAA;
                alu_a      = {24'b0, raw_q};
                alu_cf     = cf_q;
                alu_af     = af_q;
                state_next = (idx < len_q) ? ST_ADD : ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            len_q   <= '0;
            idx     <= '0;
            raw_q   <= '0;
            cf_q    <= 1'b0;
            af_q    <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: if (start) begin
                    a_q     <= a_bcd;
                    b_q     <= b_bcd;
                    len_q   <= len;
                    carry_q <= cin;
                    idx     <= '0;
                    sum_q   <= '0;
                    cout_q  <= 1'b0;
                    err_q   <= err_in;
                end
                ST_ADD: begin
                    // AF is recovered from the raw sum since the ALU flags are not trusted for ADD
                    raw_q <= raw_next;
                    cf_q  <= alu_out[8];
                    af_q  <= (a_byte[FLAG_AF_BIT] ^ b_byte[FLAG_AF_BIT] ^ raw_next[FLAG_AF_BIT]);
                end
                ST_DAA: begin
                    sum_q[{idx, 3'b000} +: 8] <= alu_out[7:0];
                    carry_q <= alu_flags[FLAG_CF_BIT];
                    cout_q  <= alu_flags[FLAG_CF_BIT];
                    idx     <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == ST_ADD) || (state == ST_DAA);
    assign done    = (state == ST_DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign bcd_err = err_q;

endmodule
